// File: rtl/mig_traffic_gen.sv
// ==========================================================================
// mig_traffic_gen: write-then-read-back memory traffic generator and checker
// Revision: 1.0
// ==========================================================================
`default_nettype none

module mig_traffic_gen #(
   parameter int          ADDR_W    = 27,
   parameter int          DATA_W    = 32,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned NUM_WORDS = 1024,
   parameter int unsigned TIMEOUT   = 4095,
   parameter logic [31:0] SEED      = 32'hACE1_2468
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              loop_i,
   input  logic [1:0]        mode_i,
   input  logic              mem_ready_i,
   input  logic              mem_done_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [1:0]        mem_width_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_wstrobe_o,
   output logic              mem_rstrobe_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timeout_o,
   output logic [15:0]       err_count_o,
   output logic [ADDR_W-1:0] first_err_addr_o,
   output logic [15:0]       pass_count_o
);

   localparam int          IDX_W = 21;
   localparam int          SH_W  = $clog2(DATA_W);
   localparam logic [31:0] TAPS  = 32'h8020_0003;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_WAIT = 3'd2,
      RD_REQ  = 3'd3,
      RD_WAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [1:0]        mode_q, mode_d;
   logic [31:0]       tmr_q, tmr_d;
   logic              stop_q, stop_d;
   logic [15:0]       err_q, err_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;
   logic [15:0]       pass_q, pass_d;
   logic              tout_q, tout_d;

   logic [DATA_W-1:0] lfsr_pat;
   logic [DATA_W-1:0] pattern;
   logic [31:0]       lfsr_adv;
   logic              last_word;
   logic              tmr_end;
   logic              stop_seen;
   logic              busy;

   generate
      if (DATA_W == 16) begin : g_lfsr16
         assign lfsr_pat = lfsr_q[15:0];
      end else if (DATA_W == 64) begin : g_lfsr64
         assign lfsr_pat = {lfsr_q, lfsr_q};
      end else begin : g_lfsr32
         assign lfsr_pat = lfsr_q;
      end
   endgenerate

   // The same pattern drives write data and the read-back expectation.
   always_comb begin
      pattern = '0;
      case (mode_q)
         2'd0:    pattern = DATA_W'(idx_q);
         2'd1:    pattern = {{(DATA_W-1){1'b0}}, 1'b1} << idx_q[SH_W-1:0];
         2'd2:    pattern = lfsr_pat;
         default: pattern = idx_q[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
      endcase
   end

   assign lfsr_adv  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
   assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));
   assign tmr_end   = (tmr_q == 32'(TIMEOUT - 1));
   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign stop_seen = stop_q | stop_i;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      addr_d        = addr_q;
      lfsr_d        = lfsr_q;
      mode_d        = mode_q;
      tmr_d         = tmr_q;
      stop_d        = stop_q;
      err_d         = err_q;
      ferr_d        = ferr_q;
      pass_d        = pass_q;
      tout_d        = tout_q;
      mem_wstrobe_o = 1'b0;
      mem_rstrobe_o = 1'b0;

      if (busy && stop_i) begin
         stop_d = 1'b1;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = WR_REQ;
               idx_d   = '0;
               addr_d  = ADDR_W'(BASE_ADDR);
               lfsr_d  = SEED;
               mode_d  = mode_i;
               stop_d  = 1'b0;
               err_d   = '0;
               ferr_d  = '0;
               pass_d  = '0;
               tout_d  = 1'b0;
            end
         end
         WR_REQ, RD_REQ: begin
            if (mem_ready_i) begin
               mem_wstrobe_o = (state_q == WR_REQ);
               mem_rstrobe_o = (state_q == RD_REQ);
               state_d       = (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
               tmr_d         = '0;
            end
         end
         WR_WAIT, RD_WAIT: begin
            if (mem_done_i) begin
               if (state_q == RD_WAIT && mem_rdata_i != pattern) begin
                  if (err_q != 16'hFFFF) begin
                     err_d = err_q + 16'd1;
                  end
                  if (err_q == 16'd0) begin
                     ferr_d = addr_q;
                  end
               end
               if (state_q == RD_WAIT && last_word) begin
                  pass_d = pass_q + 16'd1;
               end
               // Word advance; a phase boundary restarts index, address and LFSR.
               if (last_word) begin
                  idx_d  = '0;
                  addr_d = ADDR_W'(BASE_ADDR);
                  lfsr_d = SEED;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  addr_d = addr_q + ADDR_W'(DATA_W / 8);
                  lfsr_d = lfsr_adv;
               end
               if (stop_seen) begin
                  state_d = DONE;
               end else if (state_q == WR_WAIT) begin
                  state_d = last_word ? RD_REQ : WR_REQ;
               end else if (!last_word) begin
                  state_d = RD_REQ;
               end else begin
                  state_d = loop_i ? WR_REQ : DONE;
               end
            end else if (tmr_end) begin
               tout_d  = 1'b1;
               state_d = DONE;
            end else begin
               tmr_d = tmr_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= ADDR_W'(BASE_ADDR);
         lfsr_q  <= SEED;
         mode_q  <= 2'd0;
         tmr_q   <= '0;
         stop_q  <= 1'b0;
         err_q   <= '0;
         ferr_q  <= '0;
         pass_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         lfsr_q  <= lfsr_d;
         mode_q  <= mode_d;
         tmr_q   <= tmr_d;
         stop_q  <= stop_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         pass_q  <= pass_d;
         tout_q  <= tout_d;
      end
   end

   assign mem_addr_o       = addr_q;
   assign mem_width_o      = 2'b10;
   assign mem_wdata_o      = pattern;
   assign busy_o           = busy;
   assign done_o           = (state_q == DONE);
   assign pass_o           = (state_q == DONE) && (err_q == 16'd0) && !tout_q && (pass_q != 16'd0);
   assign timeout_o        = tout_q;
   assign err_count_o      = err_q;
   assign first_err_addr_o = ferr_q;
   assign pass_count_o     = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_mig_traffic_gen.sv
// ==========================================================================
// tb_mig_traffic_gen: directed self-checking bench for mig_traffic_gen
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_mig_traffic_gen;

   localparam int AW = 27;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic          loop_i = 1'b0;
   logic [1:0]    mode_i = 2'd0;
   logic          mem_ready_i = 1'b1;
   logic          mem_done_i = 1'b0;
   logic [DW-1:0] mem_rdata_i = '0;
   logic [AW-1:0] mem_addr_o;
   logic [1:0]    mem_width_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_wstrobe_o, mem_rstrobe_o;
   logic          busy_o, done_o, pass_o, timeout_o;
   logic [15:0]   err_count_o, pass_count_o;
   logic [AW-1:0] first_err_addr_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   mig_traffic_gen #(
      .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0), .NUM_WORDS(4),
      .TIMEOUT(15), .SEED(32'h0000_0001)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
      .loop_i(loop_i), .mode_i(mode_i), .mem_ready_i(mem_ready_i),
      .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i),
      .mem_addr_o(mem_addr_o), .mem_width_o(mem_width_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrobe_o(mem_wstrobe_o),
      .mem_rstrobe_o(mem_rstrobe_o), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
      .first_err_addr_o(first_err_addr_o), .pass_count_o(pass_count_o)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Memory model: 3-cycle latency, optional bit-0 flip on reads at byte 8.
   logic [31:0] mem [0:15];
   logic [31:0] wr_addr [0:127];
   logic [31:0] wr_data [0:127];
   int          wr_n = 0;
   int          rd_n = 0;
   int          cnt = 0;
   logic        pend = 1'b0;
   logic        is_rd = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic        noresp = 1'b0;
   logic        flip = 1'b0;

   always @(negedge clk_i) begin
      mem_done_i = 1'b0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            pend = 1'b0;
            if (!noresp) begin
               mem_done_i = 1'b1;
               if (is_rd) begin
                  mem_rdata_i = mem[p_addr[5:2]] ^ ((flip && p_addr == 27'd8) ? 32'h1 : 32'h0);
                  rd_n++;
               end
            end
         end
      end
      if (mem_wstrobe_o || mem_rstrobe_o) begin
         pend   = 1'b1;
         cnt    = 3;
         is_rd  = mem_rstrobe_o;
         p_addr = mem_addr_o;
         if (mem_wstrobe_o) begin
            mem[mem_addr_o[5:2]] = mem_wdata_o;
            wr_addr[wr_n[6:0]]   = 32'(mem_addr_o);
            wr_data[wr_n[6:0]]   = mem_wdata_o;
            wr_n++;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] m);
      tick();
      mode_i  = m;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      @(negedge clk_i);
      while (!done_o && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      check_eq(tag, done_o, 1);
   endtask

   initial begin
      int base;
      int rbase;
      int n;
      int seen;

      repeat (3) tick();
      reset_i = 1'b0;
      @(negedge clk_i);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_pass", pass_o, 0);
      check_eq("rst_tout", timeout_o, 0);
      check_eq("rst_err", err_count_o, 0);
      check_eq("rst_pcnt", pass_count_o, 0);
      check_eq("rst_addr", mem_addr_o, 0);
      check_eq("rst_wdata", mem_wdata_o, 0);
      check_eq("rst_width", mem_width_o, 2'b10);
      check_eq("rst_ferr", first_err_addr_o, 0);

      // mode 0: counting pattern
      base = wr_n; rbase = rd_n;
      pulse_start(2'd0);
      wait_done("m0_done");
      check_eq("m0_nwr", wr_n - base, 4);
      check_eq("m0_nrd", rd_n - rbase, 4);
      for (int k = 0; k < 4; k++) begin
         check_eq("m0_waddr", wr_addr[base + k], 4 * k);
         check_eq("m0_wdata", wr_data[base + k], k);
      end
      check_eq("m0_pass", pass_o, 1);
      check_eq("m0_pcnt", pass_count_o, 1);
      check_eq("m0_err", err_count_o, 0);

      // mode 1: walking one
      base = wr_n;
      pulse_start(2'd1);
      wait_done("m1_done");
      check_eq("m1_w1", wr_data[base + 1], 32'h2);
      check_eq("m1_w3", wr_data[base + 3], 32'h8);
      check_eq("m1_pass", pass_o, 1);

      // mode 3: alternating 55/AA
      base = wr_n;
      pulse_start(2'd3);
      wait_done("m3_done");
      check_eq("m3_w0", wr_data[base], 32'h5555_5555);
      check_eq("m3_w1", wr_data[base + 1], 32'hAAAA_AAAA);
      check_eq("m3_w2", wr_data[base + 2], 32'h5555_5555);

      // mode 2: LFSR from seed 1, read of byte 8 corrupted
      base = wr_n;
      flip = 1'b1;
      pulse_start(2'd2);
      wait_done("m2_done");
      flip = 1'b0;
      check_eq("m2_w0", wr_data[base], 32'h0000_0001);
      check_eq("m2_w1", wr_data[base + 1], 32'h8020_0003);
      check_eq("m2_w2", wr_data[base + 2], 32'hC030_0002);
      check_eq("m2_w3", wr_data[base + 3], 32'h6018_0001);
      check_eq("m2_err", err_count_o, 1);
      check_eq("m2_ferr", first_err_addr_o, 8);
      check_eq("m2_pass", pass_o, 0);
      check_eq("m2_pcnt", pass_count_o, 1);

      // reset from DONE clears status
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      @(negedge clk_i);
      check_eq("rd_err", err_count_o, 0);
      check_eq("rd_ferr", first_err_addr_o, 0);
      check_eq("rd_pcnt", pass_count_o, 0);
      check_eq("rd_done", done_o, 0);

      // ready held low for 10 cycles
      tick();
      mem_ready_i = 1'b0;
      pulse_start(2'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (mem_wstrobe_o || mem_rstrobe_o) seen++;
      end
      check_eq("rdy_nostb", seen, 0);
      check_eq("rdy_busy", busy_o, 1);
      tick();
      mem_ready_i = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk_i);
         if (mem_wstrobe_o) seen++;
      end
      check_eq("rdy_onestb", seen, 1);
      wait_done("rdy_done");
      check_eq("rdy_pass", pass_o, 1);

      // timeout: memory never answers
      tick();
      noresp = 1'b1;
      pulse_start(2'd0);
      n = 0;
      @(negedge clk_i);
      while (!mem_wstrobe_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("to_stb", mem_wstrobe_o, 1);
      n = 0;
      while (!done_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("to_cycles", n, 16);
      check_eq("to_flag", timeout_o, 1);
      check_eq("to_pass", pass_o, 0);
      noresp = 1'b0;

      // loop for 3 passes, stop during a read of pass 4
      tick();
      rbase = rd_n;
      loop_i = 1'b1;
      pulse_start(2'd0);
      n = 0;
      while (pass_count_o != 16'd3 && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("lp_pcnt3", pass_count_o, 3);
      n = 0;
      @(negedge clk_i);
      while (!mem_rstrobe_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("lp_rstb", mem_rstrobe_o, 1);
      tick();
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      loop_i = 1'b0;
      wait_done("lp_done");
      check_eq("lp_pcnt", pass_count_o, 3);
      check_eq("lp_nrd", rd_n - rbase, 13);
      check_eq("lp_pass", pass_o, 1);

      // reset during WR_WAIT, late completion ignored
      pulse_start(2'd0);
      n = 0;
      @(negedge clk_i);
      while (!mem_wstrobe_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("rw_stb", mem_wstrobe_o, 1);
      tick();
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      @(negedge clk_i);
      check_eq("rw_busy", busy_o, 0);
      check_eq("rw_err", err_count_o, 0);
      check_eq("rw_pcnt", pass_count_o, 0);
      repeat (6) @(negedge clk_i);
      check_eq("rw_busy2", busy_o, 0);
      check_eq("rw_done2", done_o, 0);
      check_eq("rw_addr2", mem_addr_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/mig_traffic_gen.md
MIG_TRAFFIC_GEN -- requirements
Module: mig_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, byte-address width of the memory-side port.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values are 16, 32 and 64.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first byte address tested; aligned to DATA_W/8.
REQ-004 SHALL have parameter NUM_WORDS, default 1024, words per pass; legal range is 1 to 2^20.
REQ-005 SHALL have parameter TIMEOUT, default 4095, maximum cycles allowed from strobe to mem_done_i.
REQ-006 SHALL have parameter SEED, default 32'hACE1_2468, non-zero LFSR seed.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 SHALL provide these ports (name, direction, width, meaning):
- clk_i  in  1  single clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  pulse that begins a test
- stop_i  in  1  request to end after the current transaction
- loop_i  in  1  repeat passes continuously
- mode_i  in  2  pattern select, sampled at start
- mem_ready_i  in  1  subsystem accepts a strobe
- mem_done_i  in  1  transaction_complete pulse
- mem_rdata_i  in  DATA_W  read data, valid with mem_done_i
- mem_addr_o  out  ADDR_W  byte address
- mem_width_o  out  2  constant 2'b10, full DATA_W access
- mem_wdata_o  out  DATA_W  write data
- mem_wstrobe_o, mem_rstrobe_o  out  1 each  one-cycle request pulses
- busy_o, done_o, pass_o, timeout_o  out  1 each  status
- err_count_o  out  16  mismatch count
- first_err_addr_o  out  ADDR_W  address of the first mismatch
- pass_count_o  out  16  completed passes

Function
REQ-009 SHALL implement the FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT and DONE.
REQ-010 SHALL go from IDLE to WR_REQ on start_i; start_i is ignored in every other state except DONE, where it restarts the test and clears the status outputs.
REQ-011 SHALL, in WR_REQ and RD_REQ, assert the matching strobe for exactly one cycle on the first cycle mem_ready_i=1, then enter WR_WAIT or RD_WAIT; it SHALL not strobe while mem_ready_i=0.
REQ-012 SHALL hold mem_addr_o and mem_wdata_o stable from the strobe cycle until mem_done_i.
REQ-013 SHALL leave a *_WAIT state on the cycle mem_done_i=1, increment the word index i, and drive mem_addr_o = BASE_ADDR + i*(DATA_W/8) with ADDR_W wrap-around.
REQ-014 SHALL go from WR_WAIT to RD_REQ after word NUM_WORDS-1, with i reset to 0; the read-phase pattern generator restarts identically.
REQ-015 SHALL generate the pattern for word i as follows:
- mode 0: i zero-extended
- mode 1: a single 1 at bit (i mod DATA_W)
- mode 2: a 32-bit Galois LFSR (taps for x^32+x^22+x^2+x+1) loaded with SEED, advanced once per word; DATA_W=16 takes the low 16 bits, DATA_W=64 takes {lfsr,lfsr}
- mode 3: 0x55..55 for even i, 0xAA..AA for odd i
REQ-016 SHALL, on the mem_done_i cycle in RD_WAIT, compare mem_rdata_i with the expected pattern; on a mismatch it SHALL increment err_count_o, saturating at 16'hFFFF, and capture first_err_addr_o only when err_count_o was 0.
REQ-017 SHALL, after read word NUM_WORDS-1, increment pass_count_o (wrapping), then re-enter WR_REQ with i=0 and a reseeded LFSR if loop_i=1 and stop_i has not been seen; otherwise it SHALL go to DONE.
REQ-018 SHALL latch stop_i while busy; the latched stop takes effect at the next transaction completion, which goes to DONE; a stop in the same cycle as start_i is ignored.
REQ-019 SHALL count cycles in each *_WAIT state; on reaching TIMEOUT without mem_done_i it SHALL set timeout_o and go to DONE; mem_done_i arriving on the terminal-count cycle wins over the timeout.
REQ-020 SHALL drive busy_o=1 in every state except IDLE and DONE, and done_o=1 in DONE.
REQ-021 SHALL drive pass_o=1 in DONE only when err_count_o=0, timeout_o=0 and pass_count_o>=1.
REQ-022 SHALL ignore mem_done_i in IDLE, WR_REQ, RD_REQ and DONE.

Reset
REQ-023 SHALL, on reset_i=1 in any state (mid-transaction included), enter IDLE on the next edge.
REQ-024 SHALL clear on reset all strobes, busy_o, done_o, pass_o, timeout_o, err_count_o, first_err_addr_o, pass_count_o and i, and set mem_addr_o=BASE_ADDR, mem_wdata_o=0, mem_width_o=2'b10 and the LFSR to SEED.

Verification
REQ-025 SHALL pass this case: NUM_WORDS=4, mode 0, ideal memory with 3-cycle latency -> writes 0,1,2,3 to addresses 0,4,8,12, reads match, done_o=1, pass_o=1, pass_count_o=1.
REQ-026 SHALL pass this case: mode 2, memory that flips bit 0 of the read at byte address 8 -> err_count_o=1, first_err_addr_o=8, pass_o=0.
REQ-027 SHALL pass this case: mem_ready_i held 0 for 10 cycles after start -> no strobe until mem_ready_i rises, then exactly one mem_wstrobe_o pulse.
REQ-028 SHALL pass this case: TIMEOUT=15, memory never returns mem_done_i -> timeout_o=1 and done_o=1 sixteen cycles after the strobe.
REQ-029 SHALL pass this case: loop_i=1 for 3 passes, then stop_i pulsed during a read -> DONE after that read completes, pass_count_o=3.
REQ-030 SHALL pass this case: reset_i asserted during WR_WAIT -> next cycle busy_o=0, counters 0, and a later mem_done_i is ignored.
